// File: rtl/scale_frame_collector.sv
// Byte-serial frame collector: finds the 0xA5 header, gathers 9 payload bytes and a checksum, and holds the decoded fields under a frame handshake.
// Define SCALE_COLLECT_TIMEOUT_EN to build the inter-byte idle timeout.
module scale_frame_collector #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] weight,
  output logic [7:0] height,
  output logic [7:0] wf,
  output logic [7:0] hf,
  output logic [7:0] af,
  output logic [7:0] wm,
  output logic [7:0] hm,
  output logic [7:0] am,
  output logic       s,
  output logic [2:0] bmdrange,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       err_frame,
  output logic       err_timeout,
  output logic [7:0] err_count
);

  // state   | meaning
  // HUNT    | discard bytes until header 0xA5
  // PAYLOAD | collect bytes 1..9 into shadow, accumulate sum
  // CHECK   | compare checksum byte, publish or reject
  // HOLD    | frame_valid high until frame_ready
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, HOLD} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       frame_ok;
  logic       timeout_hit;
  logic       err_inc;
  logic [3:0] idx;
  logic [7:0] sum;
  logic [7:0] shadow [9];

  assign frame_ok = (in_data == sum) && (shadow[0][7:5] == 3'b000);
  assign err_inc  = (state == CHECK && accept && !frame_ok) || timeout_hit;

`ifdef SCALE_COLLECT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;

  // Reloaded on every accept; hitting zero with no accept is the timeout edge.
  always_ff @(posedge clk) begin
    if (rst || state == HUNT || state == HOLD || accept)
      idle_cnt <= CW'(TIMEOUT_CYCLES - 1);
    else if (idle_cnt != '0)
      idle_cnt <= idle_cnt - CW'(1);
  end

  assign timeout_hit = (state == PAYLOAD || state == CHECK) && !accept && (idle_cnt == '0);
`else
  // No idle counter; the comparison folds to constant 0 and keeps the parameter referenced.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (accept && in_data == 8'hA5) state_nxt = PAYLOAD;
      PAYLOAD: if (timeout_hit) state_nxt = HUNT;
               else if (accept && idx == 4'd8) state_nxt = CHECK;
      CHECK:   if (timeout_hit) state_nxt = HUNT;
               else if (accept) state_nxt = frame_ok ? HOLD : HUNT;
      HOLD:    if (frame_ready) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    in_ready    = !rst && (state != HOLD);
    frame_valid = (state == HOLD);
    accept      = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && accept) shadow[idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      sum         <= '0;
      weight      <= '0;
      height      <= '0;
      wf          <= '0;
      hf          <= '0;
      af          <= '0;
      wm          <= '0;
      hm          <= '0;
      am          <= '0;
      s           <= 1'b0;
      bmdrange    <= '0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      err_frame   <= state == CHECK && accept && !frame_ok;
      err_timeout <= timeout_hit;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      case (state)
        HUNT: if (accept) begin
          idx <= '0;
          sum <= '0;
        end
        PAYLOAD: if (accept) begin
          sum <= sum + in_data;
          idx <= idx + 4'd1;
        end
        CHECK: if (accept && frame_ok) begin
          weight   <= {shadow[0][0], shadow[1]};
          s        <= shadow[0][4];
          bmdrange <= shadow[0][3:1];
          height   <= shadow[2];
          wf       <= shadow[3];
          hf       <= shadow[4];
          af       <= shadow[5];
          wm       <= shadow[6];
          hm       <= shadow[7];
          am       <= shadow[8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_frame_collector.sv
// Randomized bench for scale_frame_collector: frames are built and judged at the frame level
// (sum of payload, reserved bits) and the DUT's handshake, fields and error counters are compared.
module tb_scale_frame_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] weight;
  logic [7:0] height, wf, hf, af, wm, hm, am;
  logic       s;
  logic [2:0] bmdrange;
  logic       frame_valid;
  logic       frame_ready;
  logic       err_frame;
  logic       err_timeout;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [79:0] exp_fields;
  int          exp_err;

  always #5 clk = ~clk;

`ifdef SCALE_COLLECT_TIMEOUT_EN
  scale_frame_collector #(.TIMEOUT_CYCLES(10)) dut (
`else
  scale_frame_collector dut (
`endif
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weight(weight), .height(height), .wf(wf), .hf(hf), .af(af), .wm(wm), .hm(hm), .am(am),
    .s(s), .bmdrange(bmdrange), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .err_frame(err_frame), .err_timeout(err_timeout), .err_count(err_count));

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] dut_fields();
    return {weight, height, wf, hf, af, wm, hm, am, s, bmdrange};
  endfunction

  // Fields decoded straight from the frame layout.
  function automatic logic [79:0] decode(input logic [7:0] f [11]);
    return {f[1][0], f[2], f[3], f[4], f[5], f[6], f[7], f[8], f[9], f[10 - 10 + 1][4], f[1][3:1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit done = 0;
    repeat ($urandom_range(0, max_gap)) begin
      in_valid    = 1'b0;
      frame_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    if (!done) check_val("accept_budget", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] f [11], input int max_gap);
    logic [7:0] total = 8'h00;
    bit good;
    int k;
    for (int i = 1; i <= 9; i++) total = total + f[i];
    good = (total == f[10]) && (f[1][7:5] == 3'b000);
    for (int i = 0; i < 11; i++) send_byte(f[i], max_gap);
    frame_ready = 1'b0;
    if (good) begin
      exp_fields = decode(f);
      check_val("valid_after_chk", frame_valid, 1);
      check_val("fields", dut_fields(), exp_fields);
      check_val("err_frame_quiet", err_frame, 0);
      check_val("err_count_good", err_count, exp_err);
      k = $urandom_range(0, 5);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (k) begin
        step();
        check_val("hold_in_ready", in_ready, 0);
        check_val("hold_valid", frame_valid, 1);
      end
      frame_ready = 1'b1;
      step();
      check_val("release_valid", frame_valid, 0);
      check_val("release_in_ready", in_ready, 1);
      frame_ready = 1'b0;
      in_valid    = 1'b0;
    end else begin
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      check_val("err_frame_pulse", err_frame, 1);
      check_val("bad_valid_low", frame_valid, 0);
      check_val("bad_fields_kept", dut_fields(), exp_fields);
      check_val("err_count_bad", err_count, exp_err);
      step();
      check_val("err_frame_1cyc", err_frame, 0);
    end
    check_val("no_timeout", err_timeout, 0);
  endtask

  function automatic void make_frame(output logic [7:0] f [11], input int kind);
    logic [7:0] total = 8'h00;
    f[0] = 8'hA5;
    f[1] = {3'b000, 5'($urandom_range(0, 31))};
    if (kind == 2) f[1][7:5] = 3'($urandom_range(1, 7));
    for (int i = 2; i <= 9; i++) f[i] = 8'($urandom_range(0, 255));
    for (int i = 1; i <= 9; i++) total = total + f[i];
    f[10] = (kind == 1) ? total + 8'($urandom_range(1, 255)) : total;
  endfunction

  initial begin
    logic [7:0] f [11];
    logic [7:0] g;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; frame_ready = 1'b0;
    exp_fields = '0; exp_err = 0;
    repeat (3) step();
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_fields", dut_fields(), 0);
    check_val("rst_valid", frame_valid, 0);
    check_val("rst_err_count", err_count, 0);
    rst = 1'b0;
    #1;
    check_val("in_ready_after_rst", in_ready, 1);

    f = '{8'hA5, 8'h0F, 8'h4B, 8'hAA, 8'h50, 8'hAA, 8'h1E, 8'h50, 8'hAA, 8'h1E, 8'h34};
    run_frame(f, 0);
    check_val("plan_weight", weight, 9'h14B);
    check_val("plan_bmd", {s, bmdrange}, 4'h7);
    f[10] = 8'h35;
    run_frame(f, 0);
    check_val("plan_err_count", err_count, 1);
    f[1] = 8'h8F; f[10] = 8'hB4;
    run_frame(f, 0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    f[1] = 8'h0F; f[10] = 8'h34;
    run_frame(f, 0);

`ifdef SCALE_COLLECT_TIMEOUT_EN
    send_byte(8'hA5, 0); send_byte(8'h0F, 0); send_byte(8'h4B, 0);
    repeat (9) begin
      step();
      check_val("timeout_early", err_timeout, 0);
    end
    step();
    exp_err++;
    check_val("timeout_pulse", err_timeout, 1);
    check_val("timeout_count", err_count, exp_err);
    step();
    check_val("timeout_1cyc", err_timeout, 0);
    run_frame(f, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 99);
      make_frame(f, r < 60 ? 0 : (r < 80 ? 1 : 2));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin
          g = 8'($urandom_range(0, 255));
          if (g == 8'hA5) g = 8'h5A;
          send_byte(g, 2);
        end
      run_frame(f, 3);
    end

    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fields = '0; exp_err = 0;
    check_val("midrst_fields", dut_fields(), 0);
    check_val("midrst_err_count", err_count, 0);
    check_val("midrst_valid", frame_valid, 0);
    make_frame(f, 0);
    run_frame(f, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
